led_cube_uart_tx: RTL and testbench

LED_CUBE_UART_TX -- requirements
Module: led_cube_uart_tx

---
 rtl/led_cube_uart_pkg.sv | 24 ++
 rtl/led_cube_byte_fifo.sv | 54 +++++
 rtl/led_cube_uart_tx.sv | 128 ++++++++++++
 tb/tb_led_cube_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_cube_uart_pkg.sv
// Shared definitions for the LED-cube UART transmit path: Avalon register
// indices of the UART slave, status-register bit positions, and the
// transmit FSM state encoding.
package led_cube_uart_pkg;

  localparam logic [4:0] REG_RXDATA  = 5'd0;
  localparam logic [4:0] REG_TXDATA  = 5'd1;
  localparam logic [4:0] REG_STATUS  = 5'd2;
  localparam logic [4:0] REG_CONTROL = 5'd3;

  localparam int STAT_TMT  = 5;
  localparam int STAT_TRDY = 6;
  localparam int STAT_RRDY = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POLL      = 3'd1,
    POLL_WAIT = 3'd2,
    CHECK     = 3'd3,
    WRITE     = 3'd4,
    GAP       = 3'd5
  } state_e;

endpackage

// File: rtl/led_cube_byte_fifo.sv
// Byte FIFO buffering transmit data ahead of the UART. DEPTH must be a power
// of two so the read/write pointers wrap naturally at their width.
module led_cube_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  // A push into a full FIFO is dropped even if a pop happens the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; reset discards all contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/led_cube_uart_tx.sv
// Drains a byte FIFO into an Avalon-MM UART: polls STATUS for TRDY before
// every byte, backs off POLL_GAP cycles when the transmitter is busy, then
// writes the byte to TXDATA.
//
//   state     | meaning
//   IDLE      | waiting for a byte in the FIFO
//   POLL      | status read strobe, held through waitrequest
//   POLL_WAIT | waiting for readdatavalid, captures TRDY
//   CHECK     | decide between writing and backing off
//   WRITE     | txdata write strobe, held through waitrequest; pops on accept
//   GAP       | back-off down-counter before the next poll
module led_cube_uart_tx
  import led_cube_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_GAP   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [4:0]                    avalon_master_address,
  output logic                          avalon_master_read,
  output logic                          avalon_master_write,
  output logic [15:0]                   avalon_master_writedata,
  input  logic [15:0]                   avalon_master_readdata,
  input  logic                          avalon_master_readdatavalid,
  input  logic                          avalon_master_waitrequest
);

  state_e     state_q, state_d;
  logic       trdy_q, trdy_d;
  logic [7:0] gap_q, gap_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_pop;
  logic       unused_rdata;

  // Only the TRDY bit of the status word matters here.
  assign unused_rdata = ^{avalon_master_readdata[15:STAT_TRDY+1],
                          avalon_master_readdata[STAT_TRDY-1:0]};

  assign tx_ready = !fifo_full;
  assign busy     = !fifo_empty || (state_q != IDLE);

  led_cube_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid && tx_ready),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state and bus outputs; strobes are decoded straight from the state.
  always_comb begin
    state_d                 = state_q;
    trdy_d                  = trdy_q;
    gap_d                   = gap_q;
    fifo_pop                = 1'b0;
    avalon_master_read      = 1'b0;
    avalon_master_write     = 1'b0;
    avalon_master_address   = REG_RXDATA;
    avalon_master_writedata = 16'h0000;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = POLL;
      end
      POLL: begin
        avalon_master_read    = 1'b1;
        avalon_master_address = REG_STATUS;
        if (!avalon_master_waitrequest) state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (avalon_master_readdatavalid) begin
          trdy_d  = avalon_master_readdata[STAT_TRDY];
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (trdy_q) begin
          state_d = WRITE;
        end else begin
          gap_d   = 8'(POLL_GAP - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == 8'd0) state_d = POLL;
        else               gap_d   = gap_q - 8'd1;
      end
      WRITE: begin
        avalon_master_write     = 1'b1;
        avalon_master_address   = REG_TXDATA;
        avalon_master_writedata = {8'h00, fifo_dout};
        if (!avalon_master_waitrequest) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, captured TRDY and back-off counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      trdy_q  <= 1'b0;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      trdy_q  <= trdy_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_led_cube_uart_tx.sv
// Bench for led_cube_uart_tx: an Avalon UART slave model answers status polls
// with scripted or random TRDY values, a monitor logs every accepted bus
// transfer, and the checks compare that log against expected byte order,
// poll counts, spacing and FIFO occupancy.
module tb_led_cube_uart_tx;

  localparam int DEPTH = 8;
  localparam int GAPC  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic [4:0]    address;
  logic          rd;
  logic          wr;
  logic [15:0]   writedata;
  logic [15:0]   readdata = 16'h0000;
  logic          rdv = 1'b0;
  logic          waitreq;

  int n_tests = 0;
  int n_fail  = 0;

  // slave model knobs (written only by the stimulus block)
  int          trdy_mode = 0;     // 0: always ready, 1: never ready, 2: random
  bit          trdy_script[$];
  bit          hold_rdv = 1'b0;
  bit          inj_rdv = 1'b0;
  logic [15:0] inj_data = 16'h0000;
  int          wr_wait = 0;

  // monitor state (written only by the monitor block)
  int          cyc = 0;
  int          n_reads = 0;
  int          n_wr_cycles = 0;
  int          pops = 0;
  int          bad_addr = 0;
  int          overlap = 0;
  int          unstable = 0;
  int          wr_hold = 0;
  int          read_cyc[$];
  logic [15:0] wr_log[$];
  bit          prev_pending = 1'b0;
  logic [4:0]  prev_addr = '0;
  logic [15:0] prev_wd = '0;

  always #5 clk = ~clk;

  assign waitreq = wr && (wr_hold < wr_wait);

  led_cube_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .POLL_GAP   (GAPC)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .tx_data                     (tx_data),
    .tx_valid                    (tx_valid),
    .tx_ready                    (tx_ready),
    .busy                        (busy),
    .fifo_level                  (fifo_level),
    .avalon_master_address       (address),
    .avalon_master_read          (rd),
    .avalon_master_write         (wr),
    .avalon_master_writedata     (writedata),
    .avalon_master_readdata      (readdata),
    .avalon_master_readdatavalid (rdv),
    .avalon_master_waitrequest   (waitreq)
  );

  function automatic bit next_trdy();
    if (trdy_script.size() > 0) return trdy_script.pop_front();
    if (trdy_mode == 0) return 1'b1;
    if (trdy_mode == 1) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  // UART slave: status data one cycle after an accepted read, other bits random
  always @(posedge clk) begin
    rdv <= 1'b0;
    if (inj_rdv) begin
      rdv      <= 1'b1;
      readdata <= inj_data;
    end else if (rd && !waitreq && !hold_rdv) begin
      rdv      <= 1'b1;
      readdata <= (16'($urandom) & ~16'h0040) | (next_trdy() ? 16'h0040 : 16'h0000);
    end
    if (wr && waitreq) wr_hold <= wr_hold + 1;
    else               wr_hold <= 0;
  end

  // Bus monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd && wr) overlap <= overlap + 1;
    if (rd && !waitreq) begin
      n_reads <= n_reads + 1;
      read_cyc.push_back(cyc);
      if (address != 5'd2) bad_addr <= bad_addr + 1;
    end
    if (wr) begin
      n_wr_cycles <= n_wr_cycles + 1;
      if (prev_pending && (address != prev_addr || writedata != prev_wd))
        unstable <= unstable + 1;
      if (!waitreq) begin
        wr_log.push_back(writedata);
        pops <= pops + 1;
        if (address != 5'd1) bad_addr <= bad_addr + 1;
      end
    end
    prev_pending <= wr && waitreq;
    prev_addr    <= address;
    prev_wd      <= writedata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k = 0;
    while (busy && k < maxc) begin
      step();
      k++;
    end
    check(tag, 32'(k < maxc), 32'd1);
  endtask

  initial begin
    int rb, wb, k, acc, pbase;
    logic [7:0] exp_q[$];

    // ---- reset values
    rst_n = 1'b0;
    repeat (2) step();
    check("rst_read",      32'(rd), 32'd0);
    check("rst_write",     32'(wr), 32'd0);
    check("rst_address",   32'(address), 32'd0);
    check("rst_writedata", 32'(writedata), 32'd0);
    check("rst_tx_ready",  32'(tx_ready), 32'd1);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_level",     32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    step();

    // ---- single byte, ready slave: latency and bus sequence
    rb = n_reads; wb = wr_log.size();
    tx_data = 8'h41; tx_valid = 1'b1;
    k = 0;
    do begin
      step();
      k++;
      tx_valid = 1'b0;
    end while (!wr && k < 20);
    check("latency", 32'(k), 32'd5);
    wait_idle("idle_41", 50);
    check("reads_41",  32'(n_reads - rb), 32'd1);
    check("writes_41", 32'(wr_log.size() - wb), 32'd1);
    if (wr_log.size() > wb) check("data_41", 32'(wr_log[wb]), 32'h0041);
    check("busy_41", 32'(busy), 32'd0);

    // ---- three not-ready polls before the write
    trdy_script = '{1'b0, 1'b0, 1'b0};
    rb = n_reads; wb = wr_log.size();
    push_byte(8'h55);
    wait_idle("idle_55", 200);
    check("reads_55",  32'(n_reads - rb), 32'd4);
    check("writes_55", 32'(wr_log.size() - wb), 32'd1);
    if (wr_log.size() > wb) check("data_55", 32'(wr_log[wb]), 32'h0055);
    if (read_cyc.size() >= rb + 4)
      for (int i = 1; i < 4; i++)
        check("poll_spacing", 32'(read_cyc[rb+i] - read_cyc[rb+i-1]), 32'(3 + GAPC));

    // ---- write held off by waitrequest
    wr_wait = 3;
    wb = wr_log.size(); k = n_wr_cycles; pbase = pops;
    push_byte(8'hA7);
    wait_idle("idle_a7", 100);
    check("wr_cycles_a7", 32'(n_wr_cycles - k), 32'd4);
    check("pops_a7",      32'(pops - pbase), 32'd1);
    if (wr_log.size() > wb) check("data_a7", 32'(wr_log[wb]), 32'h00A7);
    check("level_a7", 32'(fifo_level), 32'd0);
    wr_wait = 0;

    // ---- fill to full with the UART never ready
    trdy_mode = 1;
    wb = wr_log.size();
    acc = 0;
    for (int i = 1; i <= 9; i++) begin
      check("tx_ready_fill", 32'(tx_ready), 32'(acc < DEPTH));
      if (tx_ready) acc++;
      tx_data = 8'(i); tx_valid = 1'b1;
      step();
    end
    tx_valid = 1'b0;
    check("full_ready", 32'(tx_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    trdy_mode = 0;
    wait_idle("idle_fill", 500);
    check("fill_writes", 32'(wr_log.size() - wb), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      if (wr_log.size() > wb + i) check("fill_order", 32'(wr_log[wb+i]), 32'(i + 1));

    // ---- random traffic against a queue model
    trdy_mode = 2;
    wb = wr_log.size(); pbase = pops; acc = 0;
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      logic push_now;
      logic [7:0] b;
      b = 8'($urandom);
      wr_wait = $urandom_range(0, 2);
      push_now = ($urandom_range(0, 9) < 7) && tx_ready;
      tx_data = b; tx_valid = push_now;
      step();
      tx_valid = 1'b0;
      if (push_now) begin
        acc++;
        exp_q.push_back(b);
      end
      check("rand_level", 32'(fifo_level), 32'(acc - (pops - pbase)));
    end
    wait_idle("idle_rand", 3000);
    check("rand_count", 32'(wr_log.size() - wb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (wr_log.size() > wb + i) check("rand_data", 32'(wr_log[wb+i]), {24'h0, exp_q[i]});
    trdy_mode = 0;
    wr_wait = 0;

    // ---- reset while waiting for status data, three bytes queued
    hold_rdv = 1'b1;
    rb = n_reads;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    k = 0;
    while (n_reads == rb && k < 20) begin step(); k++; end
    check("pw_reached", 32'(n_reads > rb), 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_read",  32'(rd), 32'd0);
    check("mid_rst_write", 32'(wr), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    rst_n = 1'b1;
    hold_rdv = 1'b0;
    rb = n_reads; wb = wr_log.size();
    inj_data = 16'h0040; inj_rdv = 1'b1;
    step();
    inj_rdv = 1'b0;
    repeat (15) step();
    check("late_rdv_writes", 32'(wr_log.size() - wb), 32'd0);
    check("late_rdv_reads",  32'(n_reads - rb), 32'd0);
    check("late_rdv_busy",   32'(busy), 32'd0);

    // ---- spurious readdatavalid in IDLE must not pre-load TRDY
    inj_data = 16'h0040; inj_rdv = 1'b1;
    step();
    inj_rdv = 1'b0;
    repeat (8) step();
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_writes", 32'(wr_log.size() - wb), 32'd0);
    trdy_script = '{1'b0};
    rb = n_reads;
    push_byte(8'h3C);
    wait_idle("idle_3c", 100);
    check("repoll_reads", 32'(n_reads - rb), 32'd2);
    check("repoll_writes", 32'(wr_log.size() - wb), 32'd1);
    if (wr_log.size() > wb) check("data_3c", 32'(wr_log[wb]), 32'h003C);

    // ---- global bus-protocol invariants
    check("rw_overlap", 32'(overlap), 32'd0);
    check("bad_addr",   32'(bad_addr), 32'd0);
    check("wr_stable",  32'(unstable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
